ir_send_scheduler: RTL and testbench



---
 rtl/ir_send_scheduler_if.sv | 19 +
 rtl/ir_send_scheduler.sv | 156 +++++++++++++++
 tb/tb_ir_send_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ir_send_scheduler_if.sv
// Bus-side write port of the IR send scheduler: address, data and a one-cycle write strobe.
// The bus master drives all three; the scheduler only samples them.
interface ir_send_scheduler_if;
   logic [7:0] BUS_ADDR;
   logic [7:0] BUS_DATA;
   logic       BUS_WE;

   modport master (
      output BUS_ADDR,
      output BUS_DATA,
      output BUS_WE
   );

   modport slave (
      input BUS_ADDR,
      input BUS_DATA,
      input BUS_WE
   );
endinterface

// File: rtl/ir_send_scheduler.sv
// Sequences the IR packet transmitter: periodic or one-shot launches, a stretched launch
// strobe, and a COMMAND that stays frozen from each launch until the next one.
module ir_send_scheduler #(
   parameter logic [7:0] BUS_BASE_ADDR = 8'h90,
   parameter int         SEND_PERIOD   = 10_000_000,
   parameter int         HOLD_CYCLES   = 1_500_000,
   parameter int         SEND_WIDTH    = 5_000,
   parameter int         AUTO_CLEAR    = 1,
   parameter int         CNT_WIDTH     = 24
) (
   input  logic                   CLK,
   input  logic                   RESET,
   ir_send_scheduler_if.slave     bus,
   output logic [3:0]             COMMAND,
   output logic                   SEND_PACKET,
   output logic                   BUSY,
   output logic                   PACKET_DONE,
   output logic                   ENABLED
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_HOLD = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] SEND_LAST   = CNT_WIDTH'(SEND_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(SEND_PERIOD - 1);
   localparam logic [7:0]           CTRL_ADDR   = BUS_BASE_ADDR + 8'd1;

   state_t                 state_reg, state_next;
   logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
   logic [3:0]             pend_cmd_reg;
   logic                   enable_reg;
   logic                   oneshot_reg;
   logic [3:0]             command_reg, command_next;
   logic                   send_packet_reg, send_packet_next;
   logic                   busy_reg, busy_next;
   logic                   packet_done_reg, packet_done_next;
   logic                   launch;

   logic                   wr_base;
   logic                   wr_ctrl;
   logic                   unused_data_bits;

   assign wr_base          = bus.BUS_WE && (bus.BUS_ADDR == BUS_BASE_ADDR);
   assign wr_ctrl          = bus.BUS_WE && (bus.BUS_ADDR == CTRL_ADDR);
   assign unused_data_bits = ^bus.BUS_DATA[7:4];

   // Next-state and output decode; a launch overrides whatever the state arm chose.
   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      launch           = 1'b0;
      packet_done_next = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (enable_reg || oneshot_reg) begin
               launch = 1'b1;
            end
         end
         ST_SEND: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == SEND_LAST) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == HOLD_LAST) begin
               packet_done_next = 1'b1;
               // A pending one-shot launches from either WAIT or IDLE on the following cycle.
               state_next       = enable_reg ? ST_WAIT : ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_next = cnt_reg + 1'b1;
            if (oneshot_reg) begin
               launch = 1'b1;
            end else if (!enable_reg) begin
               state_next = ST_IDLE;
            end else if (cnt_reg == PERIOD_LAST) begin
               launch = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase

      if (launch) begin
         state_next = ST_SEND;
         cnt_next   = '0;
      end

      command_next     = launch ? pend_cmd_reg : command_reg;
      send_packet_next = launch || ((state_reg == ST_SEND) && (cnt_reg != SEND_LAST));
      busy_next        = launch || (state_reg == ST_SEND)
                         || ((state_reg == ST_HOLD) && (cnt_reg != HOLD_LAST));
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         command_reg     <= '0;
         send_packet_reg <= 1'b0;
         busy_reg        <= 1'b0;
         packet_done_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         command_reg     <= command_next;
         send_packet_reg <= send_packet_next;
         busy_reg        <= busy_next;
         packet_done_reg <= packet_done_next;
      end
   end

   // Bus-writable registers; a write in the launch cycle wins over the launch-side clears.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pend_cmd_reg <= '0;
         enable_reg   <= 1'b0;
         oneshot_reg  <= 1'b0;
      end else begin
         if (wr_base) begin
            pend_cmd_reg <= bus.BUS_DATA[3:0];
         end else if (launch && (AUTO_CLEAR != 0)) begin
            pend_cmd_reg <= '0;
         end

         if (wr_ctrl) begin
            enable_reg <= bus.BUS_DATA[0];
         end

         if (wr_ctrl && bus.BUS_DATA[1]) begin
            oneshot_reg <= 1'b1;
         end else if (launch) begin
            oneshot_reg <= 1'b0;
         end
      end
   end

   assign COMMAND     = command_reg;
   assign SEND_PACKET = send_packet_reg;
   assign BUSY        = busy_reg;
   assign PACKET_DONE = packet_done_reg;
   assign ENABLED     = enable_reg;

endmodule

// File: tb/tb_ir_send_scheduler.sv
// Directed bench for ir_send_scheduler with SEND_PERIOD=20, HOLD_CYCLES=8, SEND_WIDTH=3.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
module tb_ir_send_scheduler;

   logic       CLK;
   logic       RESET;
   logic [3:0] COMMAND;
   logic       SEND_PACKET;
   logic       BUSY;
   logic       PACKET_DONE;
   logic       ENABLED;

   int tests_run;
   int tests_failed;

   ir_send_scheduler_if bus ();

   ir_send_scheduler #(
      .BUS_BASE_ADDR (8'h90),
      .SEND_PERIOD   (20),
      .HOLD_CYCLES   (8),
      .SEND_WIDTH    (3),
      .AUTO_CLEAR    (1),
      .CNT_WIDTH     (8)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .bus         (bus.slave),
      .COMMAND     (COMMAND),
      .SEND_PACKET (SEND_PACKET),
      .BUSY        (BUSY),
      .PACKET_DONE (PACKET_DONE),
      .ENABLED     (ENABLED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
      bus.BUS_ADDR = addr;
      bus.BUS_DATA = data;
      bus.BUS_WE   = 1'b1;
      tick();
      bus.BUS_WE   = 1'b0;
      bus.BUS_ADDR = 8'h00;
      bus.BUS_DATA = 8'h00;
   endtask

   // Cycles from the current sample to the next rising SEND_PACKET.
   task automatic wait_launch(input int budget, output int n);
      logic prev;
      logic rose;
      n    = 0;
      rose = 1'b0;
      while (!rose && n < budget) begin
         prev = SEND_PACKET;
         tick();
         n++;
         rose = SEND_PACKET && !prev;
      end
      if (!rose) begin
         check_eq("launch_timeout", 32'(n), 32'(budget + 1));
      end
   endtask

   // Samples the launch cycle and the nine after it; bit i is cycle i after launch.
   task automatic capture_packet(output logic [9:0] send_v, output logic [9:0] busy_v,
                                 output logic [9:0] done_v);
      for (int i = 0; i < 10; i++) begin
         send_v[i] = SEND_PACKET;
         busy_v[i] = BUSY;
         done_v[i] = PACKET_DONE;
         if (i < 9) tick();
      end
   endtask

   // Counts rising SEND_PACKET edges, BUSY-high and PACKET_DONE-high samples.
   task automatic monitor(input int cycles, output int launches, output int busy_n,
                          output int done_n);
      logic prev;
      launches = 0;
      busy_n   = BUSY ? 1 : 0;
      done_n   = PACKET_DONE ? 1 : 0;
      for (int i = 0; i < cycles; i++) begin
         prev = SEND_PACKET;
         tick();
         if (SEND_PACKET && !prev) launches++;
         if (BUSY) busy_n++;
         if (PACKET_DONE) done_n++;
      end
   endtask

   initial begin
      logic [9:0] send_v, busy_v, done_v;
      int n, launches, busy_n, done_n;

      tests_run    = 0;
      tests_failed = 0;
      RESET        = 1'b1;
      bus.BUS_ADDR = 8'h00;
      bus.BUS_DATA = 8'h00;
      bus.BUS_WE   = 1'b0;
      tick();
      tick();
      check_eq("rst_command", 32'(COMMAND), 32'h0);
      check_eq("rst_outputs", {28'h0, SEND_PACKET, BUSY, PACKET_DONE, ENABLED}, 32'h0);
      RESET = 1'b0;
      tick();

      // 1: periodic launch with COMMAND=5, then auto-cleared COMMAND at the next launch
      bus_write(8'h90, 8'h05);
      bus_write(8'h91, 8'h01);
      check_eq("s1_enabled", 32'(ENABLED), 32'h1);
      check_eq("s1_no_early_send", 32'(SEND_PACKET), 32'h0);
      wait_launch(5, n);
      check_eq("s1_launch_latency", 32'(n), 32'd1);
      check_eq("s1_command", 32'(COMMAND), 32'h5);
      capture_packet(send_v, busy_v, done_v);
      check_eq("s1_send_shape", 32'(send_v), 32'h007);
      check_eq("s1_busy_shape", 32'(busy_v), 32'h0FF);
      check_eq("s1_done_shape", 32'(done_v), 32'h100);
      check_eq("s1_command_wait", 32'(COMMAND), 32'h5);
      wait_launch(40, n);
      check_eq("s1_period", 32'(n + 9), 32'd20);
      check_eq("s1_autoclear_cmd", 32'(COMMAND), 32'h0);

      // 2: write during HOLD does not disturb COMMAND until the next launch
      repeat (4) tick();
      bus_write(8'h90, 8'h0A);
      check_eq("s2_cmd_frozen", 32'(COMMAND), 32'h0);
      wait_launch(40, n);
      check_eq("s2_period", 32'(n + 5), 32'd20);
      check_eq("s2_new_cmd", 32'(COMMAND), 32'hA);

      // 3: disable, then single one-shot with COMMAND=3 and no relaunch
      bus_write(8'h91, 8'h00);
      repeat (15) tick();
      check_eq("s3_idle_busy", 32'(BUSY), 32'h0);
      check_eq("s3_idle_enabled", 32'(ENABLED), 32'h0);
      bus_write(8'h90, 8'h03);
      bus_write(8'h91, 8'h02);
      wait_launch(5, n);
      check_eq("s3_oneshot_latency", 32'(n), 32'd1);
      check_eq("s3_command", 32'(COMMAND), 32'h3);
      monitor(100, launches, busy_n, done_n);
      check_eq("s3_no_relaunch", 32'(launches), 32'd0);
      check_eq("s3_busy_len", 32'(busy_n), 32'd8);
      check_eq("s3_done_count", 32'(done_n), 32'd1);

      // 4: one-shot requested during HOLD launches right after PACKET_DONE
      bus_write(8'h91, 8'h01);
      wait_launch(5, n);
      check_eq("s4_enable_latency", 32'(n), 32'd1);
      repeat (4) tick();
      bus_write(8'h91, 8'h03);
      n = 0;
      while (!PACKET_DONE && n < 10) begin
         tick();
         n++;
      end
      check_eq("s4_done_at", 32'(n), 32'd3);
      check_eq("s4_done_send_low", {30'h0, SEND_PACKET, BUSY}, 32'h0);
      tick();
      check_eq("s4_relaunch", {29'h0, SEND_PACKET, BUSY, PACKET_DONE}, 32'h6);
      wait_launch(40, n);
      check_eq("s4_period_after_oneshot", 32'(n), 32'd20);

      // 5: disabling during SEND lets the packet finish, then stays idle
      check_eq("s5_busy_at_launch", 32'(BUSY), 32'h1);
      bus_write(8'h91, 8'h00);
      check_eq("s5_enabled", 32'(ENABLED), 32'h0);
      monitor(40, launches, busy_n, done_n);
      check_eq("s5_busy_rest", 32'(busy_n), 32'd7);
      check_eq("s5_done_count", 32'(done_n), 32'd1);
      check_eq("s5_no_relaunch", 32'(launches), 32'd0);

      // 6: reset during HOLD clears everything, including a pending command
      bus_write(8'h90, 8'h09);
      bus_write(8'h91, 8'h01);
      wait_launch(5, n);
      check_eq("s6_command", 32'(COMMAND), 32'h9);
      repeat (4) tick();
      bus_write(8'h90, 8'h06);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check_eq("s6_rst_command", 32'(COMMAND), 32'h0);
      check_eq("s6_rst_outputs", {28'h0, SEND_PACKET, BUSY, PACKET_DONE, ENABLED}, 32'h0);
      monitor(10, launches, busy_n, done_n);
      check_eq("s6_idle_after_rst", 32'(launches + busy_n + done_n), 32'd0);
      bus_write(8'h91, 8'h01);
      wait_launch(5, n);
      check_eq("s6_restart_latency", 32'(n), 32'd1);
      check_eq("s6_restart_command", 32'(COMMAND), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
